instr_fetch_reg: RTL and testbench

- Instruction fetch and instruction register stage of the multicycle CPU; sits directly upstream of the sign-extend block.
- On a fetch request from the control unit, it performs a word read from instruction memory with a ready handshake.
- It latches the returned word into the instruction register (IR) and holds it stable for all later cycles of the instruction.
- It exposes decoded fields; imm16 feeds the sign-extend block, the register-file addresses feed the register file.

---
 rtl/instr_fetch_reg.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_reg.sv
// instr_fetch_reg: instruction fetch + instruction register stage.
// A control-unit fetch request starts a word read from instruction memory.
// The read completes on a ready handshake. The returned word is latched into
// the IR and held until the next completed fetch. The decoded fields are
// plain slices of the IR.
// Optional build macro FETCH_TIMEOUT_EN adds a REQ-state timeout that aborts
// the fetch and raises a sticky fetch_err. Without the macro, REQ waits
// forever and fetch_err is tied low.
module instr_fetch_reg #(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] pc_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        ir_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jtarget,
  output logic        fetch_err
);

  // The timeout counter is 8 bits wide, so TIMEOUT_CYC must fit in 2..255.
  generate
    if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
      $error("instr_fetch_reg: TIMEOUT_CYC must be in 2..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] ir_reg;
  logic [31:0] mem_addr_reg;
  logic        mem_rd_reg;
  logic        busy_reg;
  logic        ir_valid_reg;

`ifdef FETCH_TIMEOUT_EN
  // Last count value at which REQ still waits. Reaching it with no ready aborts.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt_reg;
  logic       fetch_err_reg;
`endif

  // Fetch FSM. All control outputs and the IR are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ir_reg        <= NOP_WORD;
      mem_addr_reg  <= 32'h0;
      mem_rd_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      ir_valid_reg  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_reg  <= 8'h0;
      fetch_err_reg <= 1'b0;
`endif
    end else begin
      // ir_valid is a single-cycle pulse. It is raised only on the REQ->DONE edge.
      ir_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (fetch_req) begin
            // Force word alignment by dropping the PC byte offset.
            mem_addr_reg  <= pc_in & 32'hFFFF_FFFC;
            mem_rd_reg    <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= REQ;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_reg  <= 8'h0;
            fetch_err_reg <= 1'b0;
`endif
          end
        end

        REQ: begin
          // mem_addr stays frozen while waiting. A ready in the last allowed
          // cycle still wins over the timeout.
          if (mem_ready) begin
            ir_reg       <= mem_rdata;
            mem_rd_reg   <= 1'b0;
            ir_valid_reg <= 1'b1;
            state_reg    <= DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt_reg == TIMEOUT_LAST) begin
            // Abort: the IR keeps the previous instruction and no pulse is raised.
            mem_rd_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            fetch_err_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
`endif
        end

        DONE: begin
          // Requests seen in this cycle are dropped. The next one is taken from IDLE.
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          mem_rd_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr = mem_addr_reg;
  assign mem_rd   = mem_rd_reg;
  assign busy     = busy_reg;
  assign ir_valid = ir_valid_reg;
  assign instr    = ir_reg;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_reg;
`else
  assign fetch_err = 1'b0;
`endif

  // Decoded fields are pure slices of the IR. They change only when the IR changes.
  assign opcode  = ir_reg[31:26];
  assign rs      = ir_reg[25:21];
  assign rt      = ir_reg[20:16];
  assign rd      = ir_reg[15:11];
  assign shamt   = ir_reg[10:6];
  assign funct   = ir_reg[5:0];
  assign imm16   = ir_reg[15:0];
  assign jtarget = ir_reg[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed testbench for instr_fetch_reg.
// Inputs are driven and outputs are sampled on the falling clock edge.
// The timeout scenario runs only when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] pc_in;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        ir_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  instr_fetch_reg #(
    .TIMEOUT_CYC (16),
    .NOP_WORD    (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .pc_in     (pc_in),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .ir_valid  (ir_valid),
    .instr     (instr),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm16     (imm16),
    .jtarget   (jtarget),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it when the values differ.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to the next falling edge and tally any ir_valid pulse seen there.
  task automatic step();
    @(negedge clk);
    if (ir_valid === 1'b1) pulses++;
  endtask

  // Present a one-cycle fetch request and land in the first REQ cycle.
  task automatic start_fetch(input logic [31:0] pc);
    fetch_req = 1'b1;
    pc_in     = pc;
    step();
    fetch_req = 1'b0;
  endtask

  logic [31:0] held;
  int          rd_cycles;
  int          p0;

  initial begin
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    pc_in     = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    step();
    step();

    // Reset state
    check_eq("rst_instr",    instr,            32'h0);
    check_eq("rst_mem_rd",   {31'h0, mem_rd},  32'h0);
    check_eq("rst_mem_addr", mem_addr,         32'h0);
    check_eq("rst_busy",     {31'h0, busy},    32'h0);
    check_eq("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    check_eq("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
    rst_n = 1'b1;
    step();

    // Zero-wait fetch: ir_valid appears 2 cycles after the request edge.
    start_fetch(32'h0000_0040);
    check_eq("zw_mem_rd",    {31'h0, mem_rd},   32'h1);
    check_eq("zw_mem_addr",  mem_addr,          32'h0000_0040);
    check_eq("zw_busy",      {31'h0, busy},     32'h1);
    check_eq("zw_no_valid_yet", {31'h0, ir_valid}, 32'h0);
    mem_rdata = 32'h2008_FFFF;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_eq("zw_ir_valid",  {31'h0, ir_valid}, 32'h1);
    check_eq("zw_instr",     instr,             32'h2008_FFFF);
    check_eq("zw_opcode",    {26'h0, opcode},   32'h08);
    check_eq("zw_rs",        {27'h0, rs},       32'h0);
    check_eq("zw_rt",        {27'h0, rt},       32'h8);
    check_eq("zw_imm16",     {16'h0, imm16},    32'hFFFF);
    check_eq("zw_jtarget",   {6'h0, jtarget},   32'h0008_FFFF);
    check_eq("zw_mem_rd_low", {31'h0, mem_rd},  32'h0);
    step();
    check_eq("zw_valid_pulse_end", {31'h0, ir_valid}, 32'h0);
    check_eq("zw_idle",      {31'h0, busy},     32'h0);

    // Three wait states: mem_rd high for 4 cycles, ir_valid at N+5.
    start_fetch(32'h0000_0100);
    mem_rdata = 32'h0128_5020;
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rd === 1'b1) rd_cycles++;
      check_eq("ws_no_valid", {31'h0, ir_valid}, 32'h0);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    check_eq("ws_ir_valid",  {31'h0, ir_valid}, 32'h1);
    check_eq("ws_rd_cycles", rd_cycles,          32'd4);
    check_eq("ws_mem_rd_low", {31'h0, mem_rd},  32'h0);
    check_eq("ws_instr",     instr,             32'h0128_5020);
    check_eq("ws_rs",        {27'h0, rs},       32'd9);
    check_eq("ws_rt",        {27'h0, rt},       32'd8);
    check_eq("ws_rd",        {27'h0, rd},       32'd10);
    check_eq("ws_shamt",     {27'h0, shamt},    32'd0);
    check_eq("ws_funct",     {26'h0, funct},    32'h20);
    step();

    // Misaligned PC; requests while busy and in DONE are dropped.
    p0        = pulses;
    fetch_req = 1'b1;
    pc_in     = 32'h0000_0047;
    step();
    check_eq("mis_addr",     mem_addr,          32'h0000_0044);
    pc_in = 32'h0000_0200;
    step();
    check_eq("mis_addr_held", mem_addr,         32'h0000_0044);
    check_eq("mis_still_req", {31'h0, mem_rd},  32'h1);
    mem_rdata = 32'h8C88_0004;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_eq("mis_ir_valid", {31'h0, ir_valid}, 32'h1);
    step();
    fetch_req = 1'b0;
    check_eq("mis_busy_ignored",  {31'h0, busy},   32'h0);
    check_eq("mis_mem_rd_ignored", {31'h0, mem_rd}, 32'h0);
    held = 32'h8C88_0004;
    for (int i = 0; i < 10; i++) begin
      mem_rdata = $urandom;
      step();
      check_eq("ir_hold", instr, held);
    end
    check_eq("mis_one_pulse", pulses - p0, 32'd1);

    // Stray ready while IDLE is ignored.
    p0        = pulses;
    mem_rdata = 32'hDEAD_BEEF;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    check_eq("stray_instr",  instr,            held);
    check_eq("stray_busy",   {31'h0, busy},    32'h0);
    check_eq("stray_mem_rd", {31'h0, mem_rd},  32'h0);
    check_eq("stray_no_pulse", pulses - p0,    32'd0);
    check_eq("stray_fetch_err", {31'h0, fetch_err}, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Timeout: mem_rd stays high for 16 REQ cycles, then the error is flagged.
    p0 = pulses;
    start_fetch(32'h0000_00C0);
    rd_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_rd !== 1'b1) break;
      rd_cycles++;
      step();
    end
    check_eq("to_rd_cycles", rd_cycles,          32'd16);
    check_eq("to_fetch_err", {31'h0, fetch_err}, 32'h1);
    check_eq("to_instr",     instr,              held);
    check_eq("to_busy",      {31'h0, busy},      32'h0);
    check_eq("to_no_pulse",  pulses - p0,        32'd0);
    step();
    check_eq("to_err_sticky", {31'h0, fetch_err}, 32'h1);
    start_fetch(32'h0000_00C4);
    check_eq("to_err_cleared", {31'h0, fetch_err}, 32'h0);
    mem_rdata = 32'h2409_0005;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_eq("to_recover_valid", {31'h0, ir_valid}, 32'h1);
    check_eq("to_recover_instr", instr,            32'h2409_0005);
    held = 32'h2409_0005;
    step();
`endif

    // Asynchronous reset in the middle of REQ aborts the fetch.
    start_fetch(32'h0000_0080);
    check_eq("ar_busy_before", {31'h0, busy}, 32'h1);
    check_eq("ar_instr_before", instr,        held);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_instr",    instr,             32'h0);
    check_eq("ar_mem_rd",   {31'h0, mem_rd},   32'h0);
    check_eq("ar_busy",     {31'h0, busy},     32'h0);
    check_eq("ar_ir_valid", {31'h0, ir_valid}, 32'h0);
    check_eq("ar_mem_addr", mem_addr,          32'h0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("ar_stays_idle", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
